phase_gen: RTL and testbench

- Parametrised multi-channel phase generator (NCO phase front end) feeding the sincos CORDIC block(s) in the inverter modulator.
- Replaces the fixed-step ramp, which snapped to -pi on wrap. This block preserves the wrap residue.
- Adds a runtime-programmable signed increment, N channels at equal 2*pi/NCH spacing (three-phase by default), and AXI-stream valid/ready backpressure.
- Phase format: signed Q(PHASE_W-FRAC_W).FRAC_W radians, range [-PI_POS, PI_POS).

---
 rtl/inverter_pkg.sv | 39 +++
 rtl/phase_wrap.sv | 39 +++
 rtl/phase_gen.sv | 138 +++++++++++++
 tb/tb_phase_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inverter_pkg.sv
// Shared fixed-point angle helpers for the inverter modulator blocks.
// Angles are signed radians in Q(PHASE_W-FRAC_W).FRAC_W format.
package inverter_pkg;

    localparam int FRAC_W_DEFAULT = 13;

    localparam int PI_POS_Q13     = 25736;
    localparam int PI_NEG_Q13     = -25736;
    localparam int TWO_PI_Q13     = 51472;
    localparam int THIRD_TURN_Q13 = 17157;

    // pi scaled by 2^32, rounded; rescaled down with rounding for any FRAC_W < 32
    localparam longint PI_Q32 = 64'sd13493037705;

    // round(pi * 2^frac_w)
    function automatic int pi_q(input int frac_w);
        longint den;
        den = longint'(1) << (32 - frac_w);
        return int'((PI_Q32 + den / 2) / den);
    endfunction

    // round(2*pi * 2^frac_w / nch): spacing between adjacent channels
    function automatic int step_q(input int frac_w, input int nch);
        longint den;
        den = longint'(nch) << (32 - frac_w);
        return int'((2 * PI_Q32 + den / 2) / den);
    endfunction

    // Channel offset -k*STEP folded into [-pi, pi) so one wrap correction suffices downstream
    function automatic int offset_q(input int k, input int frac_w, input int nch);
        int v;
        v = -k * step_q(frac_w, nch);
        if (v < -pi_q(frac_w)) begin
            v = v + 2 * pi_q(frac_w);
        end
        return v;
    endfunction

endpackage

// File: rtl/phase_wrap.sv
// Signed add with a single +/-2*pi correction into [-PI_POS, PI_POS).
// Valid while both operands lie in [-PI_POS, PI_POS].
module phase_wrap #(
    parameter int PHASE_W = 16,
    parameter int PI_POS  = 25736
) (
    input  logic signed [PHASE_W-1:0] i_a,
    input  logic signed [PHASE_W-1:0] i_b,
    output logic signed [PHASE_W-1:0] o_y,
    output logic                      o_wrapped
);

    // Two guard bits keep the raw sum and its correction free of overflow
    localparam int EXT_W = PHASE_W + 2;
    localparam logic signed [EXT_W-1:0] C_PI     = EXT_W'(PI_POS);
    localparam logic signed [EXT_W-1:0] C_NEG_PI = EXT_W'(-PI_POS);
    localparam logic signed [EXT_W-1:0] C_TWO_PI = EXT_W'(2 * PI_POS);

    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_fix;

    assign w_sum = {{2{i_a[PHASE_W-1]}}, i_a} + {{2{i_b[PHASE_W-1]}}, i_b};

    // Fold the sum back into range, flagging when a correction was applied
    always_comb begin
        w_fix     = w_sum;
        o_wrapped = 1'b0;
        if (w_sum >= C_PI) begin
            w_fix     = w_sum - C_TWO_PI;
            o_wrapped = 1'b1;
        end else if (w_sum < C_NEG_PI) begin
            w_fix     = w_sum + C_TWO_PI;
            o_wrapped = 1'b1;
        end
    end

    assign o_y = w_fix[PHASE_W-1:0];

endmodule

// File: rtl/phase_gen.sv
// Multi-channel NCO phase front end with AXI-stream output.
// Emits NCH phases spaced 2*pi/NCH apart, keeping the wrap residue.
// Optional macro PHASE_GEN_RESYNC_EN adds the resync input (restart at phase 0).
module phase_gen
    import inverter_pkg::*;
#(
    parameter int PHASE_W     = 16,
    parameter int FRAC_W      = FRAC_W_DEFAULT,
    parameter int NCH         = 3,
    parameter int DEFAULT_INC = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [PHASE_W-1:0] phase_inc,
    input  logic                      inc_load,
`ifdef PHASE_GEN_RESYNC_EN
    input  logic                      resync,
`endif
    output logic [NCH*PHASE_W-1:0]    phase_tdata,
    output logic                      phase_tvalid,
    input  logic                      phase_tready,
    output logic                      phase_tuser
);

    localparam int PI_POS = pi_q(FRAC_W);
    localparam logic signed [PHASE_W-1:0] C_PI_POS = PHASE_W'(PI_POS);
    localparam logic signed [PHASE_W-1:0] C_PI_NEG = PHASE_W'(-PI_POS);

    logic signed [PHASE_W-1:0] r_acc;
    logic signed [PHASE_W-1:0] r_inc;
    logic                      r_wrap_flag;
    logic [NCH*PHASE_W-1:0]    r_tdata;
    logic                      r_tvalid;
    logic                      r_tuser;

    logic                      w_advance;
    logic signed [PHASE_W-1:0] w_acc_base;
    logic                      w_tuser_next;
    logic signed [PHASE_W-1:0] w_acc_next;
    logic                      w_acc_wrapped;
    logic signed [PHASE_W-1:0] w_inc_clamped;
    logic [NCH*PHASE_W-1:0]    w_ch;

    // A new beat is produced when enabled and the output slot is empty or draining
    assign w_advance = en & (~r_tvalid | phase_tready);

`ifdef PHASE_GEN_RESYNC_EN
    logic r_resync_pend;
    logic w_resync_now;

    assign w_resync_now = resync | r_resync_pend;
    assign w_acc_base   = w_resync_now ? '0 : r_acc;
    assign w_tuser_next = w_resync_now ? 1'b1 : r_wrap_flag;

    // Hold a resync request until the next beat can absorb it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resync_pend <= 1'b0;
        end else if (w_advance) begin
            r_resync_pend <= 1'b0;
        end else if (resync) begin
            r_resync_pend <= 1'b1;
        end
    end
`else
    assign w_acc_base   = r_acc;
    assign w_tuser_next = r_wrap_flag;
`endif

    // Increment is limited to half a turn so one wrap correction is always enough
    always_comb begin
        w_inc_clamped = phase_inc;
        if (phase_inc > C_PI_POS) begin
            w_inc_clamped = C_PI_POS;
        end else if (phase_inc < C_PI_NEG) begin
            w_inc_clamped = C_PI_NEG;
        end
    end

    phase_wrap #(
        .PHASE_W (PHASE_W),
        .PI_POS  (PI_POS)
    ) u_acc_wrap (
        .i_a       (w_acc_base),
        .i_b       (r_inc),
        .o_y       (w_acc_next),
        .o_wrapped (w_acc_wrapped)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic signed [PHASE_W-1:0] C_OFFSET = PHASE_W'(offset_q(gi, FRAC_W, NCH));
            logic w_unused_wrap;

            phase_wrap #(
                .PHASE_W (PHASE_W),
                .PI_POS  (PI_POS)
            ) u_ch_wrap (
                .i_a       (w_acc_base),
                .i_b       (C_OFFSET),
                .o_y       (w_ch[gi*PHASE_W +: PHASE_W]),
                .o_wrapped (w_unused_wrap)
            );
        end
    endgenerate

    // Accumulator, increment register and the output beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_inc       <= PHASE_W'(DEFAULT_INC);
            r_wrap_flag <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tuser     <= 1'b0;
        end else begin
            if (inc_load) begin
                r_inc <= w_inc_clamped;
            end
            if (w_advance) begin
                r_tvalid    <= 1'b1;
                r_tdata     <= w_ch;
                r_tuser     <= w_tuser_next;
                r_acc       <= w_acc_next;
                r_wrap_flag <= w_acc_wrapped;
            end else if (phase_tready & ~en) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign phase_tdata  = r_tdata;
    assign phase_tvalid = r_tvalid;
    assign phase_tuser  = r_tuser;

endmodule

// File: tb/tb_phase_gen.sv
// Scoreboard bench for phase_gen: an integer phase model pushes each expected
// beat when an advance is driven; a negedge monitor pops it on transfer.
module tb_phase_gen;

    localparam int PW   = 16;
    localparam int NCH  = 3;
    localparam int PI   = 25736;
    localparam int STEP = 17157;

    typedef struct packed {
        logic [NCH*PW-1:0] data;
        logic              user;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic signed [PW-1:0] phase_inc;
    logic                 inc_load;
    logic                 resync;
    logic [NCH*PW-1:0]    phase_tdata;
    logic                 phase_tvalid;
    logic                 phase_tready;
    logic                 phase_tuser;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    int m_acc, m_inc, m_flag, m_pend;
    int n_tuser;
    logic signed [PW-1:0] last_tuser_ch0;

    logic              prev_stall = 1'b0;
    logic [NCH*PW-1:0] held_data;
    logic              held_user;

    phase_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .phase_inc    (phase_inc),
        .inc_load     (inc_load),
`ifdef PHASE_GEN_RESYNC_EN
        .resync       (resync),
`endif
        .phase_tdata  (phase_tdata),
        .phase_tvalid (phase_tvalid),
        .phase_tready (phase_tready),
        .phase_tuser  (phase_tuser)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Full modulo reduction into [-PI, PI)
    function automatic int mwrap(input int x);
        int y;
        y = x;
        while (y >= PI) y = y - 2 * PI;
        while (y < -PI) y = y + 2 * PI;
        return y;
    endfunction

    function automatic int mclamp(input int v);
        if (v > PI) return PI;
        if (v < -PI) return -PI;
        return v;
    endfunction

    task automatic model_push(input bit res);
        beat_t b;
        int base, c, nxt;
        base   = res ? 0 : m_acc;
        b.user = res ? 1'b1 : m_flag[0];
        b.data = '0;
        for (int k = 0; k < NCH; k++) begin
            c = mwrap(base - k * STEP);
            b.data[k*PW +: PW] = c[PW-1:0];
        end
        nxt    = base + m_inc;
        m_flag = (nxt >= PI || nxt < -PI) ? 1 : 0;
        m_acc  = mwrap(nxt);
        m_pend = 0;
        sb_q.push_back(b);
    endtask

    // Monitor: stall stability and scoreboard pop on each transfer
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            checks++;
            if (phase_tvalid !== 1'b1 || phase_tdata !== held_data || phase_tuser !== held_user) begin
                errors++;
                $display("FAIL stall_hold valid=%b data=%h user=%b required valid=1 data=%h user=%b",
                         phase_tvalid, phase_tdata, phase_tuser, held_data, held_user);
            end
        end
        prev_stall = phase_tvalid && !phase_tready && !rst;
        held_data  = phase_tdata;
        held_user  = phase_tuser;
        if (phase_tvalid && phase_tready && !rst) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat data=%h user=%b required no beat", phase_tdata, phase_tuser);
            end else begin
                e = sb_q.pop_front();
                if (phase_tdata !== e.data || phase_tuser !== e.user) begin
                    errors++;
                    $display("FAIL beat data=%h user=%b required data=%h user=%b",
                             phase_tdata, phase_tuser, e.data, e.user);
                end
            end
            $display("beat ch0=%0d ch1=%0d ch2=%0d tuser=%b", $signed(phase_tdata[15:0]),
                     $signed(phase_tdata[31:16]), $signed(phase_tdata[47:32]), phase_tuser);
            if (phase_tuser) begin
                n_tuser++;
                last_tuser_ch0 = phase_tdata[PW-1:0];
            end
        end
    end

    task automatic model_reset();
        m_acc  = 0;
        m_inc  = 256;
        m_flag = 0;
        m_pend = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        sb_q.delete();
        model_reset();
        rst = 1'b0;
    endtask

    // Drive en until n advances happen; stall_mask bit i drops tready on iteration i
    task automatic drive_beats(input int n, input logic [63:0] stall_mask,
                               input int load_at, input int load_val, input int resync_at);
        int   cnt;
        int   it;
        logic v;
        cnt = 0;
        it  = 0;
        while (cnt < n && it < 1000) begin
            en           = 1'b1;
            phase_tready = (it < 64) ? !stall_mask[it] : 1'b1;
            inc_load     = (it == load_at);
            phase_inc    = PW'(load_val);
            resync       = (it == resync_at);
            v            = phase_tvalid;
            @(posedge clk);
            if (!v || phase_tready) begin
                model_push(resync || (m_pend != 0));
                cnt++;
            end else if (resync) begin
                m_pend = 1;
            end
            if (inc_load) m_inc = mclamp(load_val);
            #1;
            inc_load = 1'b0;
            resync   = 1'b0;
            it++;
        end
        en = 1'b0;
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL advance_budget advances=%0d required=%0d", cnt, n);
        end
    endtask

    task automatic drain();
        int t;
        t            = 0;
        en           = 1'b0;
        phase_tready = 1'b1;
        while ((sb_q.size() != 0 || phase_tvalid) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (sb_q.size() != 0 || phase_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drain pending=%0d valid=%b required pending=0 valid=0", sb_q.size(), phase_tvalid);
        end
    endtask

    task automatic load_inc(input int val);
        en        = 1'b0;
        inc_load  = 1'b1;
        phase_inc = PW'(val);
        @(posedge clk);
        m_inc = mclamp(val);
        #1;
        inc_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (phase_tvalid !== 1'b0 || phase_tdata !== '0 || phase_tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid=%b data=%h user=%b required 0/0/0",
                     phase_tvalid, phase_tdata, phase_tuser);
        end
    endtask

    task automatic test_ramp();
        logic signed [PW-1:0] e_ch1;
        logic signed [PW-1:0] e_ch2;
        e_ch1        = -16'sd17157;
        e_ch2        = 16'sd17158;
        en           = 1'b1;
        phase_tready = 1'b1;
        @(posedge clk);
        model_push(1'b0);
        #1;
        checks++;
        if (phase_tvalid !== 1'b1 || phase_tdata[15:0] !== 16'd0) begin
            errors++;
            $display("FAIL first_beat_latency valid=%b ch0=%0d required valid=1 ch0=0",
                     phase_tvalid, $signed(phase_tdata[15:0]));
        end
        checks++;
        if ($signed(phase_tdata[31:16]) !== e_ch1 || $signed(phase_tdata[47:32]) !== e_ch2) begin
            errors++;
            $display("FAIL first_beat_offsets ch1=%0d ch2=%0d required ch1=%0d ch2=%0d",
                     $signed(phase_tdata[31:16]), $signed(phase_tdata[47:32]), e_ch1, e_ch2);
        end
        drive_beats(3, 64'd0, -1, 0, -1);
        drain();
    endtask

    task automatic test_wrap_residue();
        n_tuser = 0;
        drive_beats(102, 64'd0, -1, 0, -1);
        drain();
        checks++;
        if (n_tuser != 1 || last_tuser_ch0 !== -16'sd25616) begin
            errors++;
            $display("FAIL wrap_residue tuser_beats=%0d ch0=%0d required 1 beat ch0=-25616",
                     n_tuser, last_tuser_ch0);
        end
    endtask

    task automatic test_backpressure();
        drive_beats(8, 64'b111000, -1, 0, -1);
        drain();
    endtask

    task automatic test_inc_load();
        load_inc(30000);
        drive_beats(3, 64'd0, -1, 0, -1);
        drain();
        load_inc(-30000);
        drive_beats(3, 64'd0, -1, 0, -1);
        drain();
        drive_beats(4, 64'd0, 1, 256, -1);
        drain();
    endtask

    task automatic test_en_toggle();
        drive_beats(3, 64'd0, -1, 0, -1);
        drain();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (phase_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid valid=%b required 0", phase_tvalid);
        end
        drive_beats(3, 64'd0, -1, 0, -1);
        drain();
    endtask

    task automatic test_reverse();
        do_reset();
        load_inc(-256);
        n_tuser = 0;
        drive_beats(102, 64'd0, -1, 0, -1);
        drain();
        checks++;
        if (n_tuser != 1 || last_tuser_ch0 !== 16'sd25616) begin
            errors++;
            $display("FAIL reverse_wrap tuser_beats=%0d ch0=%0d required 1 beat ch0=25616",
                     n_tuser, last_tuser_ch0);
        end
    endtask

    task automatic test_reset_mid();
        drive_beats(3, 64'd0, -1, 0, -1);
        phase_tready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (phase_tvalid !== 1'b0 || phase_tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b user=%b required valid=0 user=0", phase_tvalid, phase_tuser);
        end
        sb_q.delete();
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst          = 1'b0;
        phase_tready = 1'b1;
        drive_beats(2, 64'd0, -1, 0, -1);
        drain();
    endtask

`ifdef PHASE_GEN_RESYNC_EN
    task automatic test_resync();
        n_tuser = 0;
        drive_beats(4, 64'b11100, -1, 0, 3);
        drain();
        checks++;
        if (n_tuser < 1 || last_tuser_ch0 !== 16'sd0) begin
            errors++;
            $display("FAIL resync tuser_beats=%0d ch0=%0d required >=1 beat ch0=0", n_tuser, last_tuser_ch0);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        phase_inc    = '0;
        inc_load     = 1'b0;
        resync       = 1'b0;
        phase_tready = 1'b1;
        n_tuser      = 0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_wrap_residue();
        test_backpressure();
        test_inc_load();
        test_en_toggle();
        test_reverse();
        test_reset_mid();
`ifdef PHASE_GEN_RESYNC_EN
        test_resync();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
